sequence_judge: RTL and testbench
=================================

Name: sequence_judge

Overview:
- Downstream of the player-input stage. Consumes one input-type event per cycle (1 toggle, 2 push, 3 mic, 4 mouse) and judges it against a target symbol sequence captured at round start.
- Tracks progress, lives and a round timer, and reports WIN or LOSE.
- Outputs drive the HEX displays and the round controller.

Parameters:
- MAX_LEN, 8: maximum number of symbols in a target sequence.
- LIVES, 3: lives loaded on a fresh game; range 1..3.
- TIME_LIMIT, 30: round duration in tick pulses; range 1..63.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low.
- start  in  1  one-cycle pulse; begins a round.
- target  in  2*MAX_LEN  packed sequence; symbol i is at bits [2i+1:2i]; code c means input type c+1.
- target_len  in  4  number of symbols in the round.
- sym_valid  in  1  qualifies sym for one cycle.
- sym  in  3  input type; valid values 1..4.
- tick  in  1  time-base enable, one pulse per timer unit.
- state  out  2  0 IDLE, 1 PLAY, 2 WIN, 3 LOSE.
- progress  out  4  count of correct symbols entered this attempt.
- lives  out  2  remaining lives.
- time_left  out  6  remaining ticks.
- hit  out  1  one-cycle pulse on a correct symbol.
- miss  out  1  one-cycle pulse on a wrong symbol.

Behaviour:
- All outputs are registered and update on the clock edge that samples the input, so latency is 1 cycle.
- Reset (reset==0 at a posedge) has priority over everything, including an active round:
  - state=IDLE, progress=0, lives=LIVES, time_left=TIME_LIMIT, hit=0, miss=0.
  - Captured target and length are cleared to 0.
- hit and miss are 0 in every cycle where they are not explicitly pulsed.
- start (honoured in IDLE, WIN or LOSE; ignored in PLAY):
  - Captures target and target_len. A length above MAX_LEN is clamped to MAX_LEN.
  - If target_len==0, start is ignored and state is unchanged.
  - Sets progress=0, time_left=TIME_LIMIT, state=PLAY.
  - lives reloads to LIVES when starting from IDLE or LOSE. From WIN, lives carries over.
- PLAY with sym_valid=1 and sym in 1..4: compare sym against captured symbol[progress] plus 1.
  - Match: hit=1, progress+1. If the new progress equals the captured length, state=WIN and progress holds at the length.
  - Mismatch: miss=1, progress=0, lives-1. If lives was 1, lives=0 and state=LOSE.
- sym_valid with sym of 0 or 5..7 has no effect and produces no pulse.
- sym_valid outside PLAY is ignored.
- Input changes after a round is captured do not affect it.
- PLAY with tick=1: time_left-1. If time_left was 1, time_left=0 and state=LOSE.
- tick outside PLAY is ignored; time_left freezes.
- Simultaneous symbol and tick in the same cycle:
  - Both are applied.
  - A completing match wins over timer expiry: state=WIN, time_left still decrements.
  - A mismatch and expiry together: state=LOSE, lives decremented, miss=1.
- start and sym_valid in the same cycle while in WIN, LOSE or IDLE: start is taken and the symbol is ignored.
- No wrap-around: progress never exceeds the length, and lives and time_left never go below 0.

Test Plan:
- Reset check: hold reset=0 for 2 cycles -> state=0, progress=0, lives=3, time_left=30, hit=miss=0.
- Clean win: target=16'h00E4 (codes 0,1,2,3), target_len=4, start; then sym 1,2,3,4 on consecutive cycles -> hit pulses each cycle, progress 1,2,3,4, state=2 one cycle after the 4th symbol, lives=3.
- Misses to loss: same target, sym 2,2,2 -> miss pulses, progress stays 0, lives 2,1,0, state=3 after the 3rd symbol. Then start -> lives=3, state=1.
- Timeout with priority: TIME_LIMIT=30, issue 29 ticks -> time_left=1, state=1. Final tick together with the completing symbol -> state=2, time_left=0. Repeat with a wrong symbol instead -> state=3, lives decremented, miss=1.
- Boundaries:
  - target_len=0 with start -> state stays 0.
  - target_len=12 -> clamped to 8, WIN after 8 correct symbols.
  - sym=5 with sym_valid -> no change.
  - start during PLAY -> ignored.
- Mid-round reset: reset=0 after progress=2 -> all reset values next cycle. A WIN-then-start sequence keeps lives=2 after one earlier miss.

Source files
------------

// File: rtl/sequence_judge.sv
// Judges player input events against a target symbol sequence captured at round start,
// tracking progress, lives and a tick-driven round timer.
module sequence_judge #(
  parameter int unsigned MAX_LEN    = 8,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned TIME_LIMIT = 30
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2*MAX_LEN-1:0]   target,
  input  logic [3:0]             target_len,
  input  logic                   sym_valid,
  input  logic [2:0]             sym,
  input  logic                   tick,
  output logic [1:0]             state,
  output logic [3:0]             progress,
  output logic [1:0]             lives,
  output logic [5:0]             time_left,
  output logic                   hit,
  output logic                   miss
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [MAX_LEN-1:0][1:0]   tgt_q, tgt_d;
  logic [3:0]                len_q, len_d;
  logic [3:0]                progress_q, progress_d;
  logic [1:0]                lives_q, lives_d;
  logic [5:0]                time_left_q, time_left_d;
  logic                      hit_q, hit_d;
  logic                      miss_q, miss_d;

  logic                      sym_ok;
  logic [1:0]                exp_code;
  logic [3:0]                next_prog;

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    len_d       = len_q;
    progress_d  = progress_q;
    lives_d     = lives_q;
    time_left_d = time_left_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;

    sym_ok   = sym_valid && (sym >= 3'd1) && (sym <= 3'd4);
    exp_code = 2'd0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (progress_q == 4'(i)) exp_code = tgt_q[i];
    end
    next_prog = progress_q + 4'd1;

    unique case (state_q)
      PLAY: begin
        if (sym_ok) begin
          if (sym == ({1'b0, exp_code} + 3'd1)) begin
            hit_d      = 1'b1;
            progress_d = next_prog;
            if (next_prog == len_q) state_d = WIN;
          end else begin
            miss_d     = 1'b1;
            progress_d = 4'd0;
            if (lives_q <= 2'd1) begin
              lives_d = 2'd0;
              state_d = LOSE;
            end else begin
              lives_d = lives_q - 2'd1;
            end
          end
        end
        // Timer expiry loses only if the same cycle's symbol did not complete the round.
        if (tick && (time_left_q != 6'd0)) begin
          time_left_d = time_left_q - 6'd1;
          if ((time_left_q == 6'd1) && (state_d != WIN)) state_d = LOSE;
        end
      end
      default: begin
        if (start && (target_len != 4'd0)) begin
          tgt_d       = target;
          len_d       = (target_len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : target_len;
          progress_d  = 4'd0;
          time_left_d = 6'(TIME_LIMIT);
          lives_d     = (state_q == WIN) ? lives_q : 2'(LIVES);
          state_d     = PLAY;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      tgt_q       <= '0;
      len_q       <= '0;
      progress_q  <= '0;
      lives_q     <= 2'(LIVES);
      time_left_q <= 6'(TIME_LIMIT);
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      len_q       <= len_d;
      progress_q  <= progress_d;
      lives_q     <= lives_d;
      time_left_q <= time_left_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  assign state     = state_q;
  assign progress  = progress_q;
  assign lives     = lives_q;
  assign time_left = time_left_q;
  assign hit       = hit_q;
  assign miss      = miss_q;

endmodule

// File: tb/tb_sequence_judge.sv
// Directed scoreboard bench for sequence_judge: driver pushes hand-computed expectations,
// monitor pops one per clock and compares the registered outputs.
module tb_sequence_judge;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] target = '0;
  logic [3:0]  target_len = '0;
  logic        sym_valid = 1'b0;
  logic [2:0]  sym = '0;
  logic        tick = 1'b0;
  logic [1:0]  state;
  logic [3:0]  progress;
  logic [1:0]  lives;
  logic [5:0]  time_left;
  logic        hit;
  logic        miss;

  typedef struct {
    logic [1:0] st;
    logic [3:0] pr;
    logic [1:0] lv;
    logic [5:0] tl;
    logic       h;
    logic       m;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  sequence_judge #(.MAX_LEN(8), .LIVES(3), .TIME_LIMIT(30)) dut (
    .clock(clock), .reset(reset), .start(start), .target(target),
    .target_len(target_len), .sym_valid(sym_valid), .sym(sym), .tick(tick),
    .state(state), .progress(progress), .lives(lives), .time_left(time_left),
    .hit(hit), .miss(miss)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one expectation is consumed per clock.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("state",     8'(state),     8'(e.st));
        chk("progress",  8'(progress),  8'(e.pr));
        chk("lives",     8'(lives),     8'(e.lv));
        chk("time_left", 8'(time_left), 8'(e.tl));
        chk("hit",       8'(hit),       8'(e.h));
        chk("miss",      8'(miss),      8'(e.m));
      end
    end
  end

  task automatic step(input logic rs, input logic st, input logic [15:0] tg, input logic [3:0] ln,
                      input logic sv, input logic [2:0] sy, input logic tk,
                      input logic [1:0] es, input logic [3:0] ep, input logic [1:0] el,
                      input logic [5:0] et, input logic eh, input logic em);
    exp_t e;
    @(negedge clock);
    reset = rs; start = st; target = tg; target_len = ln;
    sym_valid = sv; sym = sy; tick = tk;
    e.st = es; e.pr = ep; e.lv = el; e.tl = et; e.h = eh; e.m = em;
    exp_q.push_back(e);
  endtask

  // Symbol-only step with reset released and no start.
  task automatic sy_step(input logic [2:0] sy, input logic tk,
                         input logic [1:0] es, input logic [3:0] ep, input logic [1:0] el,
                         input logic [5:0] et, input logic eh, input logic em);
    step(1, 0, 16'h0000, 4'd0, 1, sy, tk, es, ep, el, et, eh, em);
  endtask

  initial begin
    // Reset for two cycles
    step(0, 0, 16'h0000, 4'd0, 0, 3'd0, 0, 2'd0, 4'd0, 2'd3, 6'd30, 0, 0);
    step(0, 0, 16'h0000, 4'd0, 0, 3'd0, 0, 2'd0, 4'd0, 2'd3, 6'd30, 0, 0);
    // Clean win
    step(1, 1, 16'h00E4, 4'd4, 0, 3'd0, 0, 2'd1, 4'd0, 2'd3, 6'd30, 0, 0);
    sy_step(3'd1, 0, 2'd1, 4'd1, 2'd3, 6'd30, 1, 0);
    sy_step(3'd2, 0, 2'd1, 4'd2, 2'd3, 6'd30, 1, 0);
    sy_step(3'd3, 0, 2'd1, 4'd3, 2'd3, 6'd30, 1, 0);
    sy_step(3'd4, 0, 2'd2, 4'd4, 2'd3, 6'd30, 1, 0);
    // Misses to loss (restart from WIN keeps 3 lives)
    step(1, 1, 16'h00E4, 4'd4, 0, 3'd0, 0, 2'd1, 4'd0, 2'd3, 6'd30, 0, 0);
    sy_step(3'd2, 0, 2'd1, 4'd0, 2'd2, 6'd30, 0, 1);
    sy_step(3'd2, 0, 2'd1, 4'd0, 2'd1, 6'd30, 0, 1);
    sy_step(3'd2, 0, 2'd3, 4'd0, 2'd0, 6'd30, 0, 1);
    step(1, 1, 16'h00E4, 4'd4, 0, 3'd0, 0, 2'd1, 4'd0, 2'd3, 6'd30, 0, 0);
    // Invalid symbol codes do nothing
    sy_step(3'd5, 0, 2'd1, 4'd0, 2'd3, 6'd30, 0, 0);
    sy_step(3'd0, 0, 2'd1, 4'd0, 2'd3, 6'd30, 0, 0);
    // start during PLAY ignored: len=1 target would win on sym 4, captured round expects 1
    step(1, 1, 16'h0003, 4'd1, 0, 3'd0, 0, 2'd1, 4'd0, 2'd3, 6'd30, 0, 0);
    sy_step(3'd1, 0, 2'd1, 4'd1, 2'd3, 6'd30, 1, 0);
    sy_step(3'd2, 0, 2'd1, 4'd2, 2'd3, 6'd30, 1, 0);
    sy_step(3'd3, 0, 2'd1, 4'd3, 2'd3, 6'd30, 1, 0);
    // Timer runs down to 1, completing symbol with final tick wins
    for (int i = 1; i <= 29; i++)
      step(1, 0, 16'h0000, 4'd0, 0, 3'd0, 1, 2'd1, 4'd3, 2'd3, 6'(30 - i), 0, 0);
    sy_step(3'd4, 1, 2'd2, 4'd4, 2'd3, 6'd0, 1, 0);
    // Same again with a wrong symbol on the final tick
    step(1, 1, 16'h00E4, 4'd4, 0, 3'd0, 0, 2'd1, 4'd0, 2'd3, 6'd30, 0, 0);
    sy_step(3'd1, 0, 2'd1, 4'd1, 2'd3, 6'd30, 1, 0);
    for (int i = 1; i <= 29; i++)
      step(1, 0, 16'h0000, 4'd0, 0, 3'd0, 1, 2'd1, 4'd1, 2'd3, 6'(30 - i), 0, 0);
    sy_step(3'd1, 1, 2'd3, 4'd0, 2'd2, 6'd0, 0, 1);
    // Outside PLAY: tick and symbols frozen, zero-length start ignored
    sy_step(3'd1, 1, 2'd3, 4'd0, 2'd2, 6'd0, 0, 0);
    step(1, 1, 16'h00E4, 4'd0, 0, 3'd0, 0, 2'd3, 4'd0, 2'd2, 6'd0, 0, 0);
    // Length 12 clamps to 8; restart from LOSE reloads lives
    step(1, 1, 16'hE4E4, 4'd12, 0, 3'd0, 0, 2'd1, 4'd0, 2'd3, 6'd30, 0, 0);
    sy_step(3'd1, 0, 2'd1, 4'd1, 2'd3, 6'd30, 1, 0);
    sy_step(3'd2, 0, 2'd1, 4'd2, 2'd3, 6'd30, 1, 0);
    sy_step(3'd3, 0, 2'd1, 4'd3, 2'd3, 6'd30, 1, 0);
    sy_step(3'd4, 0, 2'd1, 4'd4, 2'd3, 6'd30, 1, 0);
    sy_step(3'd1, 0, 2'd1, 4'd5, 2'd3, 6'd30, 1, 0);
    sy_step(3'd2, 0, 2'd1, 4'd6, 2'd3, 6'd30, 1, 0);
    sy_step(3'd3, 0, 2'd1, 4'd7, 2'd3, 6'd30, 1, 0);
    sy_step(3'd4, 0, 2'd2, 4'd8, 2'd3, 6'd30, 1, 0);
    // start with sym_valid in WIN: start taken, symbol dropped
    step(1, 1, 16'h00E4, 4'd4, 1, 3'd1, 0, 2'd1, 4'd0, 2'd3, 6'd30, 0, 0);
    sy_step(3'd1, 0, 2'd1, 4'd1, 2'd3, 6'd30, 1, 0);
    sy_step(3'd2, 1, 2'd1, 4'd2, 2'd3, 6'd29, 1, 0);
    // Mid-round reset with a valid symbol present
    step(0, 0, 16'h0000, 4'd0, 1, 3'd3, 1, 2'd0, 4'd0, 2'd3, 6'd30, 0, 0);
    step(1, 1, 16'h00E4, 4'd0, 0, 3'd0, 0, 2'd0, 4'd0, 2'd3, 6'd30, 0, 0);
    // One miss, then WIN, then start keeps lives=2
    step(1, 1, 16'h0004, 4'd2, 0, 3'd0, 0, 2'd1, 4'd0, 2'd3, 6'd30, 0, 0);
    sy_step(3'd2, 0, 2'd1, 4'd0, 2'd2, 6'd30, 0, 1);
    sy_step(3'd1, 0, 2'd1, 4'd1, 2'd2, 6'd30, 1, 0);
    sy_step(3'd2, 0, 2'd2, 4'd2, 2'd2, 6'd30, 1, 0);
    step(1, 1, 16'h0004, 4'd2, 0, 3'd0, 0, 2'd1, 4'd0, 2'd2, 6'd30, 0, 0);
    step(1, 0, 16'h0000, 4'd0, 0, 3'd0, 0, 2'd1, 4'd0, 2'd2, 6'd30, 0, 0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clock);
    #2;
    if (exp_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
